parking_occupancy: RTL

- Downstream consumer of the entry and exit direction-detect FSMs in the parking-lot design.
- Turns their completed-passage pulses into a bounded occupancy count, free-space count, full/empty status, sticky error flags and a wrapping total-entries counter.
- Its outputs drive the lot display and the "lot full" indication at the entry gate.

---
 rtl/parking_occupancy.sv | 100 ++++++++++
 1 files changed

// File: rtl/parking_occupancy.sv
// Parking-lot occupancy tracker: turns entry/exit passage pulses into a
// bounded occupancy count, free-space count, full/empty status, sticky
// error flags and a wrapping total-entries counter.
module parking_occupancy #(
  parameter int unsigned CAPACITY = 15,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned TOT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             car_in,
  input  logic             car_out,
  input  logic             err_clr,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] free,
  output logic             full,
  output logic             empty,
  output logic             err_full,
  output logic             err_empty,
  output logic [TOT_W-1:0] total_in
);

  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

  logic [CNT_W-1:0] count_q, count_d;
  logic [TOT_W-1:0] total_q, total_d;
  logic             err_full_q, err_full_d;
  logic             err_empty_q, err_empty_d;
  logic             in_d_q, in_d_d;
  logic             out_d_q, out_d_d;
  logic             ev_in, ev_out;

  // Rising-edge events plus next-state for counters and sticky flags
  always_comb begin
    count_d     = count_q;
    total_d     = total_q;
    err_full_d  = err_full_q;
    err_empty_d = err_empty_q;
    in_d_d      = car_in;
    out_d_d     = car_out;

    ev_in  = car_in & ~in_d_q;
    ev_out = car_out & ~out_d_q;

    // Clear first so that a same-cycle set condition below wins
    if (err_clr) begin
      err_full_d  = 1'b0;
      err_empty_d = 1'b0;
    end

    if (ev_in && ev_out) begin
      // A car entered and another left: occupancy unchanged, entry still counted
      total_d = total_q + TOT_W'(1);
    end else if (ev_in) begin
      if (count_q < CAP) begin
        count_d = count_q + CNT_W'(1);
        total_d = total_q + TOT_W'(1);
      end else begin
        err_full_d = 1'b1;
      end
    end else if (ev_out) begin
      if (count_q != '0) begin
        count_d = count_q - CNT_W'(1);
      end else begin
        err_empty_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      total_q     <= '0;
      err_full_q  <= 1'b0;
      err_empty_q <= 1'b0;
      in_d_q      <= 1'b0;
      out_d_q     <= 1'b0;
    end else begin
      count_q     <= count_d;
      total_q     <= total_d;
      err_full_q  <= err_full_d;
      err_empty_q <= err_empty_d;
      in_d_q      <= in_d_d;
      out_d_q     <= out_d_d;
    end
  end

  // Status derived from the count register only
  always_comb begin
    count     = count_q;
    free      = CAP - count_q;
    full      = (count_q == CAP);
    empty     = (count_q == '0);
    err_full  = err_full_q;
    err_empty = err_empty_q;
    total_in  = total_q;
  end

endmodule
